i2c_byte_master: RTL and testbench



---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_sync2.sv | 22 ++
 rtl/i2c_byte_master.sv | 185 ++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - command encodings, FSM states and quarter-bit divider helper for the I2C byte master
package i2c_pkg;

  localparam logic [2:0] I2C_CMD_START = 3'd1;
  localparam logic [2:0] I2C_CMD_WRITE = 3'd2;
  localparam logic [2:0] I2C_CMD_READ  = 3'd3;
  localparam logic [2:0] I2C_CMD_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WBIT,
    ST_WACK,
    ST_RBIT,
    ST_RACK,
    ST_STOP
  } state_t;

  // sys_clk cycles per quarter of one SCL period
  function automatic int i2c_div(input int clk_freq, input int i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// rtl/i2c_sync2.sv - two-flop synchronizer for a bus line read back from the pins
module i2c_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // idle bus reads high, so both stages reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level I2C master engine; I2C_CLK_STRETCH_EN enables SCL clock stretching
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  inout  wire        i2c_scl,
  inout  wire        i2c_sda
);

  localparam int          DIV      = i2c_div(CLK_FREQ, I2C_FREQ);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  state_t      state, n_state;
  logic [1:0]  q, n_q;
  logic [2:0]  bitn, n_bit;
  logic [15:0] cnt, n_cnt;
  logic [7:0]  tx, n_tx;
  logic [7:0]  rx, n_rx;
  logic        ack_l, n_ack;
  logic        scl_oe, n_scl;
  logic        sda_oe, n_sda;
  logic        n_rsp_valid, n_rsp_nack, n_busy;
  logic [7:0]  n_rsp_data;
  logic        enter, hold, sda_in;

  // open-drain pins: *_oe = 1 pulls the line low, otherwise release it
  assign i2c_scl   = scl_oe ? 1'b0 : 1'bz;
  assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;
  assign cmd_ready = (state == ST_IDLE);

  i2c_sync2 u_sda_sync (.clk(sys_clk), .rst_n(rst_n), .d(i2c_sda), .q(sda_in));

`ifdef I2C_CLK_STRETCH_EN
  logic scl_in;
  i2c_sync2 u_scl_sync (.clk(sys_clk), .rst_n(rst_n), .d(i2c_scl), .q(scl_in));
  // a slave holding SCL low freezes the quarter counter in Q1
  assign hold = (q == 2'd1) && !scl_in;
`else
  assign hold = 1'b0;
`endif

  // state register and all datapath registers; reset releases both lines immediately
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      q         <= 2'd0;
      bitn      <= 3'd0;
      cnt       <= 16'd0;
      tx        <= 8'h00;
      rx        <= 8'h00;
      ack_l     <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_nack  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= n_state;
      q         <= n_q;
      bitn      <= n_bit;
      cnt       <= n_cnt;
      tx        <= n_tx;
      rx        <= n_rx;
      ack_l     <= n_ack;
      scl_oe    <= n_scl;
      sda_oe    <= n_sda;
      rsp_valid <= n_rsp_valid;
      rsp_data  <= n_rsp_data;
      rsp_nack  <= n_rsp_nack;
      busy      <= n_busy;
    end
  end

  // next-state: quarter/bit sequencing, then line actions on entry to each quarter
  always_comb begin
    n_state     = state;
    n_q         = q;
    n_bit       = bitn;
    n_cnt       = cnt;
    n_tx        = tx;
    n_rx        = rx;
    n_ack       = ack_l;
    n_scl       = scl_oe;
    n_sda       = sda_oe;
    n_rsp_valid = 1'b0;
    n_rsp_data  = rsp_data;
    n_rsp_nack  = rsp_nack;
    n_busy      = busy;
    enter       = 1'b0;

    if (state == ST_IDLE) begin
      if (cmd_valid) begin
        n_cnt = 16'd0;
        n_q   = 2'd0;
        n_bit = 3'd0;
        enter = 1'b1;
        case (cmd_op)
          I2C_CMD_START: n_state = ST_START;
          I2C_CMD_WRITE: begin n_state = ST_WBIT; n_tx = cmd_data; end
          I2C_CMD_READ:  begin n_state = ST_RBIT; n_ack = cmd_nack; end
          I2C_CMD_STOP:  n_state = ST_STOP;
          default: begin enter = 1'b0; n_rsp_valid = 1'b1; end
        endcase
      end
    end else if (!hold) begin
      if (cnt != DIV_LAST) begin
        n_cnt = cnt + 16'd1;
      end else begin
        n_cnt = 16'd0;
        enter = 1'b1;
        // SCL has been high since Q1, so SDA is settled at the end of Q2
        if (q == 2'd2) begin
          if (state == ST_WACK) n_rsp_nack = sda_in;
          if (state == ST_RBIT) n_rx = {rx[6:0], sda_in};
        end
        if (q != 2'd3) begin
          n_q = q + 2'd1;
        end else begin
          n_q = 2'd0;
          case (state)
            ST_START: begin n_state = ST_IDLE; n_busy = 1'b1; end
            ST_STOP:  begin n_state = ST_IDLE; n_busy = 1'b0; end
            ST_WBIT:  if (bitn == 3'd7) n_state = ST_WACK; else n_bit = bitn + 3'd1;
            ST_RBIT:  if (bitn == 3'd7) n_state = ST_RACK; else n_bit = bitn + 3'd1;
            ST_WACK:  n_state = ST_IDLE;
            ST_RACK:  begin n_state = ST_IDLE; n_rsp_data = rx; end
            default:  n_state = ST_IDLE;
          endcase
          if (n_state == ST_IDLE) begin
            enter       = 1'b0;
            n_rsp_valid = 1'b1;
          end
        end
      end
    end

    if (enter) begin
      case (n_state)
        ST_START: begin
          case (n_q)
            2'd0: n_sda = 1'b0;
            2'd1: n_scl = 1'b0;
            2'd2: n_sda = 1'b1;
            default: n_scl = 1'b1;
          endcase
        end
        ST_STOP: begin
          case (n_q)
            2'd0: n_sda = 1'b1;
            2'd1: n_scl = 1'b0;
            2'd2: n_sda = 1'b0;
            default: ;
          endcase
        end
        default: begin
          case (n_q)
            2'd0: begin
              if (n_state == ST_WBIT)      n_sda = ~n_tx[3'd7 - n_bit];
              else if (n_state == ST_RACK) n_sda = ~n_ack;
              else                         n_sda = 1'b0;
            end
            2'd1: n_scl = 1'b0;
            2'd3: n_scl = 1'b1;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - directed self-checking bench for i2c_byte_master (I2C_CLK_STRETCH_EN adds a stretch case)
module tb_i2c_byte_master;

  localparam int DIV    = 20;
  localparam int LAT_SS = 4 * DIV + 1;
  localparam int LAT_RW = 36 * DIV + 1;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  wire        i2c_scl;
  wire        i2c_sda;

  pullup (i2c_scl);
  pullup (i2c_sda);

  int vectors = 0;
  int miscompares = 0;

  // slave model: drives 0 or z only
  int         smode = 0;
  logic [7:0] sbyte = 8'h00;
  int         sbit = 0;
  int         sbase = 0;
  int         eff;
  logic       slv_low;
  logic       scl_hold = 1'b0;

  assign i2c_sda = slv_low ? 1'b0 : 1'bz;
  assign i2c_scl = scl_hold ? 1'b0 : 1'bz;

  // line monitors
  int         cyc = 0;
  int         acc_cyc = 0;
  logic [8:0] mon_bits = 9'h0;
  int         mon_cnt = 0;
  logic       p_sda = 1'b1, p_scl = 1'b1;
  int         sda_fall_cyc = 0, sda_rise_cyc = 0, scl_fall_cyc = 0;
  logic       sda_fall_sclhi = 1'b0, sda_rise_sclhi = 1'b0;

  i2c_byte_master #(.CLK_FREQ(8_000_000), .I2C_FREQ(100_000)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_nack(cmd_nack), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_nack(rsp_nack), .busy(busy), .i2c_scl(i2c_scl), .i2c_sda(i2c_sda)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge i2c_scl) sbit <= sbit + 1;

  always @(posedge i2c_scl) begin
    mon_bits <= {mon_bits[7:0], i2c_sda};
    mon_cnt  <= mon_cnt + 1;
  end

  always @(negedge sys_clk) begin
    if (p_sda === 1'b1 && i2c_sda === 1'b0) begin sda_fall_cyc <= cyc; sda_fall_sclhi <= i2c_scl; end
    if (p_sda === 1'b0 && i2c_sda === 1'b1) begin sda_rise_cyc <= cyc; sda_rise_sclhi <= i2c_scl; end
    if (p_scl === 1'b1 && i2c_scl === 1'b0) scl_fall_cyc <= cyc;
    p_sda <= i2c_sda;
    p_scl <= i2c_scl;
  end

  // smode 1: ACK the 9th bit of a write; smode 2: send sbyte MSB first, leave the 9th bit to the master
  always_comb begin
    eff     = sbit - sbase;
    slv_low = 1'b0;
    if (smode == 1 && eff == 8) slv_low = 1'b1;
    if (smode == 2 && eff >= 0 && eff < 8) slv_low = ~sbyte[7 - eff];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic nk, output int lat);
    @(negedge sys_clk);
    cmd_op = op; cmd_data = d; cmd_nack = nk; cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 3000) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic arm_slave(input int mode, input logic [7:0] b);
    sbase = sbit;
    sbyte = b;
    smode = mode;
  endtask

  initial begin
    int lat;
    int mbase;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    check("rst_rsp_nack", {31'd0, rsp_nack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_scl", {31'd0, i2c_scl}, 32'd1);
    check("rst_sda", {31'd0, i2c_sda}, 32'd1);
    @(negedge sys_clk) rst_n = 1'b1;

    // START from an idle bus
    issue(3'd1, 8'h00, 1'b0, lat);
    check("start_lat", lat, LAT_SS);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_sda_fall_t", sda_fall_cyc - acc_cyc, 2 * DIV);
    check("start_sda_fall_sclhi", {31'd0, sda_fall_sclhi}, 32'd1);
    check("start_scl_fall_t", scl_fall_cyc - acc_cyc, 3 * DIV);

    // WRITE 0xD0 with slave ACK
    arm_slave(1, 8'h00);
    mbase = mon_cnt;
    issue(3'd2, 8'hD0, 1'b0, lat);
    smode = 0;
    check("wr_d0_lat", lat, LAT_RW);
    check("wr_d0_edges", mon_cnt - mbase, 9);
    check("wr_d0_bits", {24'd0, mon_bits[8:1]}, 32'hD0);
    check("wr_d0_ackbit", {31'd0, mon_bits[0]}, 32'd0);
    check("wr_d0_nack", {31'd0, rsp_nack}, 32'd0);

    // WRITE 0xD1 with nobody answering
    issue(3'd2, 8'hD1, 1'b0, lat);
    check("wr_d1_bits", {24'd0, mon_bits[8:1]}, 32'hD1);
    check("wr_d1_nack", {31'd0, rsp_nack}, 32'd1);
    check("wr_d1_rsp_data", {24'd0, rsp_data}, 32'h00);

    // READ 0x59, master NACKs
    arm_slave(2, 8'h59);
    issue(3'd3, 8'h00, 1'b1, lat);
    smode = 0;
    check("rd_59_lat", lat, LAT_RW);
    check("rd_59_data", {24'd0, rsp_data}, 32'h59);
    check("rd_59_bitline", {24'd0, mon_bits[8:1]}, 32'h59);
    check("rd_59_9th", {31'd0, mon_bits[0]}, 32'd1);
    check("rd_59_nack_kept", {31'd0, rsp_nack}, 32'd1);

    // READ 0x3C, master ACKs
    arm_slave(2, 8'h3C);
    issue(3'd3, 8'h00, 1'b0, lat);
    smode = 0;
    check("rd_3c_data", {24'd0, rsp_data}, 32'h3C);
    check("rd_3c_9th", {31'd0, mon_bits[0]}, 32'd0);

    // STOP
    issue(3'd4, 8'h00, 1'b0, lat);
    check("stop_lat", lat, LAT_SS);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_ready", {31'd0, cmd_ready}, 32'd1);
    check("stop_sda_rise_t", sda_rise_cyc - acc_cyc, 2 * DIV);
    check("stop_sda_rise_sclhi", {31'd0, sda_rise_sclhi}, 32'd1);

    // illegal op
    issue(3'd7, 8'hAA, 1'b0, lat);
    check("ill_lat", lat, 1);
    check("ill_scl", {31'd0, i2c_scl}, 32'd1);
    check("ill_sda", {31'd0, i2c_sda}, 32'd1);
    check("ill_rsp_data", {24'd0, rsp_data}, 32'h3C);
    check("ill_rsp_nack", {31'd0, rsp_nack}, 32'd1);

`ifdef I2C_CLK_STRETCH_EN
    // slave holds SCL low for 500 cycles at the start of a WRITE
    issue(3'd1, 8'h00, 1'b0, lat);
    scl_hold = 1'b1;
    fork
      begin repeat (500) @(posedge sys_clk); scl_hold = 1'b0; end
    join_none
    issue(3'd2, 8'hA5, 1'b0, lat);
    check("stretch_lat_min", {31'd0, lat >= LAT_RW + 500}, 32'd1);
    check("stretch_lat_max", {31'd0, lat <= LAT_RW + 560}, 32'd1);
    check("stretch_bits", {24'd0, mon_bits[8:1]}, 32'hA5);
    issue(3'd4, 8'h00, 1'b0, lat);
`endif

    // reset in the middle of a WRITE
    issue(3'd1, 8'h00, 1'b0, lat);
    mbase = mon_cnt;
    @(negedge sys_clk);
    cmd_op = 3'd2; cmd_data = 8'h00; cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (mon_cnt - mbase < 4 && lat < 2000) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    repeat (2 * DIV) @(posedge sys_clk);
    #3;
    check("mid_wr_scl_low", {31'd0, i2c_scl}, 32'd0);
    check("mid_wr_sda_low", {31'd0, i2c_sda}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_scl", {31'd0, i2c_scl}, 32'd1);
    check("arst_sda", {31'd0, i2c_sda}, 32'd1);
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_rsp_data", {24'd0, rsp_data}, 32'h00);
    check("arst_rsp_nack", {31'd0, rsp_nack}, 32'd0);
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge sys_clk) rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
